audio_dma_master: RTL and testbench

//   Bus initiator that streams stereo frames from RAM into the ADAU audio FIFO, without CPU involvement.

---
 rtl/audio_dma_pkg.sv | 23 ++
 rtl/dma_bus_reader.sv | 40 ++++
 rtl/audio_dma_master.sv | 189 ++++++++++++++++++
 tb/tb_audio_dma_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_dma_pkg.sv
// Shared types and constants for the audio DMA master: FSM state encoding,
// frame layout offsets and the fixed read-only bus constants.
package audio_dma_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_L = 3'd1,
    RD_R = 3'd2,
    PUSH = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [31:0] FRAME_STRIDE = 32'd8;
  localparam logic [31:0] RIGHT_OFS    = 32'd4;
  localparam logic [3:0]  WSTRB_READ   = 4'b0000;
  localparam logic [31:0] WDATA_IDLE   = 32'h0;

  // Frames are 8-byte aligned; the low three address bits are never used.
  function automatic logic [31:0] align_frame(input logic [31:0] a);
    return {a[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/dma_bus_reader.sv
// Single-word read sequencer on the CPU-side valid/ready bus. One instance
// serves both the left and the right word of each frame.
module dma_bus_reader #(
  parameter int SAMPLE_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic [31:0]         req_addr,
  output logic                ack,
  output logic [SAMPLE_W-1:0] sample,
  output logic                valid,
  output logic [31:0]         addr,
  input  logic [31:0]         rdata,
  input  logic                ready
);

  logic unused_rdata_hi;
  assign unused_rdata_hi = ^rdata[31:SAMPLE_W];

  // Handshake: a request raises valid on the next edge with addr loaded; valid
  // and addr then hold until an edge samples ready=1, which completes the read
  // (ack) and captures rdata. valid drops after that edge; ready with valid=0
  // has no effect.
  assign ack    = valid && ready;
  assign sample = rdata[SAMPLE_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (ack) begin
      valid <= 1'b0;
    end else if (req && !valid) begin
      valid <= 1'b1;
      addr  <= req_addr;
    end
  end

endmodule

// File: rtl/audio_dma_master.sv
// Streams stereo frames from RAM into the ADAU audio FIFO. Define
// AUDIO_DMA_LOOP_EN to replay the buffer continuously until stop.
module audio_dma_master
  import audio_dma_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int SAMPLE_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           base_addr,
  input  logic [CNT_W-1:0]      num_frames,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           addr,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  valid,
  input  logic [31:0]           rdata,
  input  logic                  ready,
  output logic [2*SAMPLE_W-1:0] adau_audio,
  output logic                  adau_audio_valid,
  input  logic                  adau_audio_full,
  output state_t                dbg_state
);

  state_t              state;
  logic                rd_req;
  logic [31:0]         rd_addr;
  logic                rd_ack;
  logic [SAMPLE_W-1:0] rd_sample;
  logic                issued;
  logic                stop_q;
  logic                stop_req;
  logic                accept;
  logic                last_frame;
  logic [31:0]         frame_addr;
  logic [CNT_W-1:0]    frames_q;
  logic [CNT_W-1:0]    idx;
  logic [SAMPLE_W-1:0] left_q;
`ifdef AUDIO_DMA_LOOP_EN
  logic [31:0]         base_q;
`endif

  assign wdata      = WDATA_IDLE;
  assign wstrb      = WSTRB_READ;
  assign dbg_state  = state;
  assign stop_req   = stop || stop_q;
  assign accept     = adau_audio_valid && !adau_audio_full;
  assign last_frame = (idx == frames_q - CNT_W'(1));

  // A read is launched once per RD_L/RD_R visit; the first one leaves with
  // the accepted start so the bus sees the request in the very next cycle.
  always_comb begin
    rd_req  = 1'b0;
    rd_addr = frame_addr;
    case (state)
      IDLE: begin
        if (start && num_frames != '0) begin
          rd_req  = 1'b1;
          rd_addr = align_frame(base_addr);
        end
      end
      RD_L: rd_req = !issued && !stop_req;
      RD_R: begin
        rd_req  = !issued && !stop_req;
        rd_addr = frame_addr + RIGHT_OFS;
      end
      default: rd_req = 1'b0;
    endcase
  end

  dma_bus_reader #(
    .SAMPLE_W (SAMPLE_W)
  ) u_reader (
    .clk      (clk),
    .reset    (reset),
    .req      (rd_req),
    .req_addr (rd_addr),
    .ack      (rd_ack),
    .sample   (rd_sample),
    .valid    (valid),
    .addr     (addr),
    .rdata    (rdata),
    .ready    (ready)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      issued           <= 1'b0;
      stop_q           <= 1'b0;
      frame_addr       <= '0;
      frames_q         <= '0;
      idx              <= '0;
      left_q           <= '0;
      adau_audio       <= '0;
      adau_audio_valid <= 1'b0;
`ifdef AUDIO_DMA_LOOP_EN
      base_q           <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (rd_req) begin
        issued <= 1'b1;
      end else if (rd_ack) begin
        issued <= 1'b0;
      end

      case (state)
        IDLE: begin
          stop_q <= 1'b0;
          if (start) begin
            busy       <= 1'b1;
            frame_addr <= align_frame(base_addr);
            frames_q   <= num_frames;
            idx        <= '0;
`ifdef AUDIO_DMA_LOOP_EN
            base_q     <= align_frame(base_addr);
`endif
            state      <= (num_frames == '0) ? DONE : RD_L;
          end
        end

        RD_L: begin
          if (stop) stop_q <= 1'b1;
          if (issued && rd_ack) begin
            left_q <= rd_sample;
            state  <= stop_req ? DONE : RD_R;
          end else if (!issued && stop_req) begin
            state <= DONE;
          end
        end

        RD_R: begin
          if (stop) stop_q <= 1'b1;
          if (issued && rd_ack) begin
            if (stop_req) begin
              state <= DONE;
            end else begin
              adau_audio       <= {left_q, rd_sample};
              adau_audio_valid <= 1'b1;
              state            <= PUSH;
            end
          end else if (!issued && stop_req) begin
            state <= DONE;
          end
        end

        // The offered frame is always delivered, even when stop is pending.
        PUSH: begin
          if (stop) stop_q <= 1'b1;
          if (accept) begin
            adau_audio_valid <= 1'b0;
            if (stop_req) begin
              state <= DONE;
            end else if (last_frame) begin
`ifdef AUDIO_DMA_LOOP_EN
              idx        <= '0;
              frame_addr <= base_q;
              state      <= RD_L;
`else
              state      <= DONE;
`endif
            end else begin
              idx        <= idx + CNT_W'(1);
              frame_addr <= frame_addr + FRAME_STRIDE;
              state      <= RD_L;
            end
          end
        end

        DONE: begin
          busy   <= 1'b0;
          done   <= 1'b1;
          stop_q <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_dma_master.sv
// Self-checking bench for audio_dma_master: directed scenarios plus randomized
// bus/FIFO back-pressure against a transaction-level frame model.
module tb_audio_dma_master;
  import audio_dma_pkg::*;

  localparam int CNT_W    = 16;
  localparam int SAMPLE_W = 24;
  localparam int AW       = 2 * SAMPLE_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [CNT_W-1:0] num_frames = '0;
  logic             busy, done, valid;
  logic [31:0]      addr, wdata;
  logic [3:0]       wstrb;
  logic [31:0]      rdata = '0;
  logic             ready = 1'b0;
  logic [AW-1:0]    adau_audio;
  logic             adau_audio_valid;
  logic             adau_audio_full = 1'b0;
  state_t           dbg_state;

  audio_dma_master #(.CNT_W(CNT_W), .SAMPLE_W(SAMPLE_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .stop             (stop),
    .base_addr        (base_addr),
    .num_frames       (num_frames),
    .busy             (busy),
    .done             (done),
    .addr             (addr),
    .wdata            (wdata),
    .wstrb            (wstrb),
    .valid            (valid),
    .rdata            (rdata),
    .ready            (ready),
    .adau_audio       (adau_audio),
    .adau_audio_valid (adau_audio_valid),
    .adau_audio_full  (adau_audio_full),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0]   exp_addr_q[$];
  logic [AW-1:0] exp_frame_q[$];
  logic [31:0]   mem_ovr [logic [31:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F11;
  endfunction

  // ---------------- bus responder, FIFO sink, monitors ----------------
  bit            mon_en = 0;
  bit            rnd_mode = 0;
  int            fixed_delay = 0, cur_delay = 0, wait_cnt = 0;
  int            full_delay = 0, push_wait = 0;
  int            rd_cnt = 0, push_cnt = 0, done_cnt = 0;
  int            done_cyc = -1, hs_cyc = -1;
  logic          prev_valid = 0, prev_hs = 0, prev_av = 0, prev_acc = 0;
  logic [31:0]   prev_addr = '0;
  logic [AW-1:0] prev_audio = '0;

  always @(negedge clk) begin
    logic [31:0] w;
    logic        hs, acc;
    if (!mon_en) begin
      prev_valid = 0; prev_hs = 0; prev_av = 0; prev_acc = 0;
      ready = 0; adau_audio_full = 0;
    end else begin
      if (prev_valid && !prev_hs) begin
        check("valid_hold", valid, 1);
        check("addr_hold", addr, prev_addr);
      end
      if (prev_hs) check("valid_drop", valid, 0);
      if (valid) check("write_consts", {wdata, wstrb}, 36'h0);

      if (valid) ready = (wait_cnt >= cur_delay);
      else       ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      hs = valid && ready;
      w  = mem_word(addr);
      if (hs) rdata = mem_ovr.exists(addr) ? w : {8'($urandom), w[23:0]};
      else    rdata = $urandom;
      if (hs) begin
        if (exp_addr_q.size() != 0) check("rd_addr", addr, exp_addr_q.pop_front());
        rd_cnt++;
        hs_cyc    = cyc;
        wait_cnt  = 0;
        cur_delay = rnd_mode ? $urandom_range(0, 3) : fixed_delay;
      end else if (valid) begin
        wait_cnt++;
      end

      if (prev_av && !prev_acc) begin
        check("av_hold", adau_audio_valid, 1);
        check("audio_hold", adau_audio, prev_audio);
      end
      if (prev_acc) check("av_drop", adau_audio_valid, 0);
      if (adau_audio_valid)
        adau_audio_full = (push_wait < full_delay) || (rnd_mode && $urandom_range(0, 2) == 0);
      else
        adau_audio_full = 1'($urandom_range(0, 1));
      acc = adau_audio_valid && !adau_audio_full;
      if (acc) begin
        if (exp_frame_q.size() != 0) check("push_data", adau_audio, exp_frame_q.pop_front());
        push_cnt++;
        push_wait = 0;
      end else if (adau_audio_valid) begin
        push_wait++;
      end

      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end

      prev_valid = valid; prev_addr = addr; prev_hs = hs;
      prev_av = adau_audio_valid; prev_audio = adau_audio; prev_acc = acc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic arm(input int d, input int f, input bit rnd);
    fixed_delay = d;
    cur_delay   = rnd ? $urandom_range(0, 3) : d;
    wait_cnt    = 0;
    full_delay  = f;
    push_wait   = 0;
    rnd_mode    = rnd;
    rd_cnt = 0; push_cnt = 0; done_cnt = 0; done_cyc = -1;
  endtask

  // exp_lat < 0 skips the latency check; stop_rd_r aborts while the first
  // right-word read is waiting for ready.
  task automatic run_xfer(input logic [31:0] base, input int n, input int d, input int f,
                          input bit rnd, input bit stop_rd_r, input int exp_lat);
    logic [31:0] b;
    int          exp_reads, exp_pushes, s_cyc;
    b = {base[31:3], 3'b000};
    exp_addr_q.delete();
    exp_frame_q.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] la, ra, lw, rw;
      la = b + 32'(8 * i);
      ra = la + 32'd4;
      lw = mem_word(la);
      rw = mem_word(ra);
      if (!stop_rd_r || i == 0) begin
        exp_addr_q.push_back(la);
        exp_addr_q.push_back(ra);
      end
      if (!stop_rd_r) exp_frame_q.push_back({lw[SAMPLE_W-1:0], rw[SAMPLE_W-1:0]});
    end
    exp_reads  = stop_rd_r ? 2 : 2 * n;
    exp_pushes = stop_rd_r ? 0 : n;
    arm(d, f, rnd);

    @(negedge clk);
    base_addr  = base;
    num_frames = CNT_W'(n);
    start      = 1'b1;
    s_cyc      = cyc;
    @(negedge clk);
    start      = 1'b0;
    base_addr  = $urandom;
    num_frames = CNT_W'($urandom_range(1, 9));
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      @(negedge clk);
      #1;
      start = (k == 1 && n > 0);
      if (stop_rd_r && valid && addr == b + 32'd4) stop = 1'b1;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    stop = 1'b0;
    check("done_count", done_cnt, 1);
    check("reads", rd_cnt, exp_reads);
    check("pushes", push_cnt, exp_pushes);
    check("busy_idle", busy, 0);
    if (exp_lat >= 0) check("done_lat", done_cyc - s_cyc, exp_lat);
    if (stop_rd_r) check("stop_done_lat", done_cyc - hs_cyc, 2);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", addr, 0);
    check("rst_audio", {adau_audio_valid, adau_audio}, 0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1;

`ifndef AUDIO_DMA_LOOP_EN
    mem_ovr[32'h0001_0000] = 32'hAA12_3456;
    mem_ovr[32'h0001_0004] = 32'hAAAB_CDEF;
    mem_ovr[32'h0001_0008] = 32'hAA00_0001;
    mem_ovr[32'h0001_000C] = 32'hAAFF_FFFF;
    run_xfer(32'h0001_0000, 2, 0, 0, 0, 0, 11);
    mem_ovr.delete();
    run_xfer(32'h0001_0105, 2, 3, 0, 0, 0, 1 + 2 * (5 + 6));
    run_xfer(32'h0001_0200, 1, 0, 6, 0, 0, 1 + (5 + 6));
`endif
    run_xfer(32'h0001_0000, 0, 0, 0, 0, 0, 2);
    run_xfer(32'h0001_0300, 3, 3, 0, 0, 1, -1);
`ifndef AUDIO_DMA_LOOP_EN
    for (int r = 0; r < 8; r++) begin
      logic [31:0] base;
      base = (r == 0) ? 32'hFFFF_FFF3 : (32'h0001_0000 | 32'($urandom_range(0, 32'h7FFF)));
      run_xfer(base, $urandom_range(1, 5), 0, 0, 1, 0, -1);
    end
`else
    exp_addr_q.delete();
    exp_frame_q.delete();
    for (int r = 0; r < 3; r++) begin
      logic [31:0] lw, rw;
      lw = mem_word(32'h0001_0000);
      rw = mem_word(32'h0001_0004);
      exp_addr_q.push_back(32'h0001_0000);
      exp_addr_q.push_back(32'h0001_0004);
      exp_frame_q.push_back({lw[SAMPLE_W-1:0], rw[SAMPLE_W-1:0]});
    end
    arm(0, 0, 0);
    @(negedge clk);
    base_addr = 32'h0001_0000; num_frames = CNT_W'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 500 && push_cnt < 3; k++) begin
      @(negedge clk);
      #1;
    end
    stop = 1'b1;
    for (int k = 0; k < 100 && done_cnt == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    stop = 1'b0;
    check("loop_reads", rd_cnt, 6);
    check("loop_pushes", push_cnt, 3);
    check("loop_done_count", done_cnt, 1);
`endif

    // asynchronous reset while the first left read is pending
    exp_addr_q.delete();
    exp_frame_q.delete();
    arm(5, 0, 0);
    @(negedge clk);
    base_addr = 32'h0001_0000; num_frames = CNT_W'(2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("pre_reset_valid", valid, 1);
    check("pre_reset_state", dbg_state, RD_L);
    reset = 1'b0;
    #1;
    check("arst_valid", valid, 0);
    check("arst_busy", busy, 0);
    check("arst_av", adau_audio_valid, 0);
    check("arst_state", dbg_state, IDLE);
    mon_en = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("post_reset_valid", valid, 0);
    check("post_reset_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
